// File: rtl/io_port_ctrl_if.sv
// Kabeta IO bus bundle between the core (master) and a memory-mapped
// peripheral (slave). IO_DataR is registered inside the slave.
interface io_port_ctrl_if #(
   parameter int DATA_WIDTH = 32
);
   logic [2:0]            IO_Addr;
   logic                  IO_EnR;
   logic                  IO_EnW;
   logic [DATA_WIDTH-1:0] IO_DataW;
   logic [DATA_WIDTH-1:0] IO_DataR;

   modport master (
      output IO_Addr,
      output IO_EnR,
      output IO_EnW,
      output IO_DataW,
      input  IO_DataR
   );

   modport slave (
      input  IO_Addr,
      input  IO_EnR,
      input  IO_EnW,
      input  IO_DataW,
      output IO_DataR
   );
endinterface

// File: rtl/io_port_ctrl.sv
// Memory-mapped I/O port: registered output pins, synchronised input pins,
// per-pin edge interrupts with selectable polarity and a lowest-index
// priority source ID.
//
// Address map: 0 OUT, 1 IN (RO), 2 IRQ_EN, 3 IRQ_PEND (W1C), 4 IRQ_POL,
// 5..7 read as zero.
module io_port_ctrl #(
   parameter int                 DATA_WIDTH  = 32,
   parameter int                 NUM_OUT     = 8,
   parameter int                 NUM_IN      = 8,
   parameter int                 SYNC_STAGES = 2,
   parameter logic [NUM_OUT-1:0] OUT_RESET   = '0,
   parameter int                 ID_W        = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
   input  logic                 Sys_Clock,
   input  logic                 Sys_Reset,
   io_port_ctrl_if.slave        io_bus,
   input  logic [NUM_IN-1:0]    Pin_In,
   output logic [NUM_OUT-1:0]   Pin_Out,
   output logic                 Irq_Req,
   output logic [ID_W-1:0]      Irq_Id
);

   localparam logic [2:0] ADDR_OUT  = 3'd0;
   localparam logic [2:0] ADDR_IN   = 3'd1;
   localparam logic [2:0] ADDR_EN   = 3'd2;
   localparam logic [2:0] ADDR_PEND = 3'd3;
   localparam logic [2:0] ADDR_POL  = 3'd4;

   logic [NUM_OUT-1:0]                  out_q,    out_d;
   logic [NUM_IN-1:0]                   irq_en_q, irq_en_d;
   logic [NUM_IN-1:0]                   pend_q,   pend_d;
   logic [NUM_IN-1:0]                   pol_q,    pol_d;
   logic [SYNC_STAGES-1:0][NUM_IN-1:0]  sync_q,   sync_d;
   logic [NUM_IN-1:0]                   prev_q,   prev_d;
   logic [DATA_WIDTH-1:0]               data_r_q, data_r_d;

   logic [NUM_IN-1:0]     pin_s;
   logic [NUM_IN-1:0]     edge_evt;
   logic [NUM_IN-1:0]     w1c_mask;
   logic [NUM_IN-1:0]     irq_act;
   logic [DATA_WIDTH-1:0] rd_val;

   assign pin_s = sync_q[SYNC_STAGES-1];

   // Synchroniser shift and previous-sample capture for edge detection.
   always_comb begin
      sync_d = sync_q;
      sync_d[0] = Pin_In;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
      prev_d = pin_s;
   end

   // Edge events per pin, polarity chosen by IRQ_POL (0 rising, 1 falling).
   always_comb begin
      edge_evt = (pin_s & ~prev_q & ~pol_q) | (~pin_s & prev_q & pol_q);
   end

   // Register writes; a pending set from an edge event beats a same-cycle W1C.
   always_comb begin
      out_d    = out_q;
      irq_en_d = irq_en_q;
      pol_d    = pol_q;
      w1c_mask = '0;
      if (io_bus.IO_EnW) begin
         case (io_bus.IO_Addr)
            ADDR_OUT:  out_d    = io_bus.IO_DataW[NUM_OUT-1:0];
            ADDR_EN:   irq_en_d = io_bus.IO_DataW[NUM_IN-1:0];
            ADDR_PEND: w1c_mask = io_bus.IO_DataW[NUM_IN-1:0];
            ADDR_POL:  pol_d    = io_bus.IO_DataW[NUM_IN-1:0];
            default:   ;
         endcase
      end
      pend_d = (pend_q & ~w1c_mask) | (edge_evt & irq_en_q);
   end

   // Read mux; the data register only loads on a read strobe, so a read
   // colliding with a write sees the pre-write value.
   always_comb begin
      rd_val = '0;
      case (io_bus.IO_Addr)
         ADDR_OUT:  rd_val[NUM_OUT-1:0] = out_q;
         ADDR_IN:   rd_val[NUM_IN-1:0]  = pin_s;
         ADDR_EN:   rd_val[NUM_IN-1:0]  = irq_en_q;
         ADDR_PEND: rd_val[NUM_IN-1:0]  = pend_q;
         ADDR_POL:  rd_val[NUM_IN-1:0]  = pol_q;
         default:   rd_val = '0;
      endcase
      data_r_d = io_bus.IO_EnR ? rd_val : data_r_q;
   end

   // Interrupt request and lowest-index source ID, straight from the flops.
   always_comb begin
      irq_act = pend_q & irq_en_q;
      Irq_Req = |irq_act;
      Irq_Id  = '0;
      for (int i = NUM_IN - 1; i >= 0; i--) begin
         if (irq_act[i]) begin
            Irq_Id = ID_W'(i);
         end
      end
   end

   // State registers, all cleared or initialised by the asynchronous reset.
   always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
      if (Sys_Reset) begin
         out_q    <= OUT_RESET;
         irq_en_q <= '0;
         pend_q   <= '0;
         pol_q    <= '0;
         sync_q   <= '0;
         prev_q   <= '0;
         data_r_q <= '0;
      end else begin
         out_q    <= out_d;
         irq_en_q <= irq_en_d;
         pend_q   <= pend_d;
         pol_q    <= pol_d;
         sync_q   <= sync_d;
         prev_q   <= prev_d;
         data_r_q <= data_r_d;
      end
   end

   assign Pin_Out         = out_q;
   assign io_bus.IO_DataR = data_r_q;

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl with 8 in / 8 out pins, OUT_RESET = 8'hA5.
module tb_io_port_ctrl;

   logic       clk_sys;
   logic       rst;
   logic [7:0] pin_in;
   logic [7:0] pin_out;
   logic       irq_req;
   logic [2:0] irq_id;
   logic [31:0] rd;

   int n_cmp;
   int n_err;

   io_port_ctrl_if #(.DATA_WIDTH(32)) bus_if ();

   io_port_ctrl #(
      .DATA_WIDTH  (32),
      .NUM_OUT     (8),
      .NUM_IN      (8),
      .SYNC_STAGES (2),
      .OUT_RESET   (8'hA5)
   ) dut (
      .Sys_Clock (clk_sys),
      .Sys_Reset (rst),
      .io_bus    (bus_if.slave),
      .Pin_In    (pin_in),
      .Pin_Out   (pin_out),
      .Irq_Req   (irq_req),
      .Irq_Id    (irq_id)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
      bus_if.IO_Addr  = addr;
      bus_if.IO_DataW = data;
      bus_if.IO_EnW   = 1'b1;
      tick();
      bus_if.IO_EnW   = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
      bus_if.IO_Addr = addr;
      bus_if.IO_EnR  = 1'b1;
      tick();
      bus_if.IO_EnR  = 1'b0;
      data = bus_if.IO_DataR;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      pin_in = 8'h00;
      bus_if.IO_Addr  = 3'd0;
      bus_if.IO_EnR   = 1'b0;
      bus_if.IO_EnW   = 1'b0;
      bus_if.IO_DataW = 32'h0;

      // 1: reset values, output write, readback
      ticks(3);
      chk("rst_pin_out", {24'h0, pin_out}, 32'hA5);
      chk("rst_data_r", bus_if.IO_DataR, 32'h0);
      chk("rst_irq_req", {31'h0, irq_req}, 32'h0);
      chk("rst_irq_id", {29'h0, irq_id}, 32'h0);
      rst = 1'b0;
      ticks(2);
      bus_write(3'd0, 32'h0000_003C);
      chk("out_write_same_edge", {24'h0, pin_out}, 32'h3C);
      bus_read(3'd0, rd);
      chk("out_read", rd, 32'h3C);
      tick();
      chk("data_r_hold", bus_if.IO_DataR, 32'h3C);
      bus_read(3'd5, rd);
      chk("unused_addr_read", rd, 32'h0);

      // 2: synchroniser latency seen through a continuous IN read
      pin_in = 8'h81;
      bus_if.IO_Addr = 3'd1;
      bus_if.IO_EnR  = 1'b1;
      tick();
      chk("in_edge1", bus_if.IO_DataR, 32'h0);
      tick();
      chk("in_edge2", bus_if.IO_DataR, 32'h0);
      tick();
      chk("in_edge3", bus_if.IO_DataR, 32'h81);
      bus_if.IO_EnR = 1'b0;
      chk("no_irq_disabled", {31'h0, irq_req}, 32'h0);
      // same-cycle read and write of OUT
      bus_if.IO_Addr  = 3'd0;
      bus_if.IO_DataW = 32'h11;
      bus_if.IO_EnR   = 1'b1;
      bus_if.IO_EnW   = 1'b1;
      tick();
      bus_if.IO_EnR   = 1'b0;
      bus_if.IO_EnW   = 1'b0;
      chk("rw_same_read_old", bus_if.IO_DataR, 32'h3C);
      chk("rw_same_pin_out", {24'h0, pin_out}, 32'h11);
      bus_write(3'd1, 32'hFF);
      bus_read(3'd1, rd);
      chk("in_write_ignored", rd, 32'h81);

      // 3: rising edge on pin 2, latency and W1C
      bus_write(3'd2, 32'h04);
      bus_write(3'd4, 32'h00);
      pin_in = 8'h85;
      ticks(2);
      chk("rise_not_yet", {31'h0, irq_req}, 32'h0);
      tick();
      chk("rise_irq_req", {31'h0, irq_req}, 32'h1);
      chk("rise_irq_id", {29'h0, irq_id}, 32'h2);
      bus_read(3'd3, rd);
      chk("rise_pend", rd, 32'h04);
      bus_write(3'd3, 32'h04);
      chk("w1c_irq_req", {31'h0, irq_req}, 32'h0);
      bus_read(3'd3, rd);
      chk("w1c_pend", rd, 32'h0);

      // 4: falling polarity on pin 3, masked pin 1
      bus_write(3'd4, 32'h08);
      bus_write(3'd2, 32'h08);
      pin_in = 8'h8D;
      ticks(4);
      chk("fallpol_rise_ignored", {31'h0, irq_req}, 32'h0);
      pin_in = 8'h85;
      ticks(4);
      chk("fall_irq_req", {31'h0, irq_req}, 32'h1);
      chk("fall_irq_id", {29'h0, irq_id}, 32'h3);
      bus_read(3'd3, rd);
      chk("fall_pend", rd, 32'h08);
      bus_write(3'd3, 32'h08);
      pin_in = 8'h8D;
      ticks(4);
      chk("fallpol_no_new", {31'h0, irq_req}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         pin_in = pin_in ^ 8'h02;
         ticks(3);
      end
      bus_read(3'd3, rd);
      chk("masked_pin1_pend", rd, 32'h0);
      bus_read(3'd4, rd);
      chk("pol_read", rd, 32'h08);

      // 5: priority and set-beats-clear
      bus_write(3'd4, 32'h00);
      bus_write(3'd2, 32'h60);
      pin_in = 8'hED;
      ticks(4);
      chk("prio_irq_req", {31'h0, irq_req}, 32'h1);
      chk("prio_irq_id", {29'h0, irq_id}, 32'h5);
      bus_read(3'd3, rd);
      chk("prio_pend", rd, 32'h60);
      pin_in = 8'hCD;
      ticks(4);
      pin_in = 8'hED;
      ticks(2);
      bus_write(3'd3, 32'h20);
      chk("set_wins_irq_id", {29'h0, irq_id}, 32'h5);
      bus_read(3'd3, rd);
      chk("set_wins_pend", rd, 32'h60);
      bus_write(3'd3, 32'h20);
      chk("plain_w1c_irq_id", {29'h0, irq_id}, 32'h6);
      bus_write(3'd2, 32'h00);
      chk("en_mask_irq_req", {31'h0, irq_req}, 32'h0);
      bus_read(3'd3, rd);
      chk("en_mask_keeps_pend", rd, 32'h40);

      // 6: asynchronous reset mid-cycle
      pin_in = 8'h00;
      ticks(4);
      bus_write(3'd4, 32'h00);
      bus_write(3'd2, 32'hFF);
      pin_in = 8'hFF;
      ticks(4);
      bus_read(3'd3, rd);
      chk("all_pend", rd, 32'hFF);
      bus_write(3'd0, 32'h00);
      chk("out_zero", {24'h0, pin_out}, 32'h00);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_irq_req", {31'h0, irq_req}, 32'h0);
      chk("arst_irq_id", {29'h0, irq_id}, 32'h0);
      chk("arst_pin_out", {24'h0, pin_out}, 32'hA5);
      chk("arst_data_r", bus_if.IO_DataR, 32'h0);
      ticks(2);
      chk("arst_held_pin_out", {24'h0, pin_out}, 32'hA5);
      rst = 1'b0;
      ticks(4);
      bus_read(3'd3, rd);
      chk("post_rst_pend", rd, 32'h0);
      bus_read(3'd2, rd);
      chk("post_rst_en", rd, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
